apx_float_error_monitor: RTL

//  Synthesizable on-chip checker that pairs results from an accurate float unit and an approximate one.

---
 rtl/apx_float_pkg.sv | 40 ++++
 rtl/float_ulp_distance.sv | 48 ++++
 rtl/apx_float_error_monitor.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/apx_float_pkg.sv
// Shared definitions for the approximate-float error monitors: default widths,
// the compare FSM encoding and the float classification / ordering helpers.
package apx_float_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_EXP_W = 8;
  localparam int MAX_W     = 64;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    COMPARE = 2'd1,
    REPORT  = 2'd2
  } state_t;

  // Word is zero-extended to MAX_W; w/ew give the real float layout.
  function automatic logic is_nan(input logic [MAX_W-1:0] x, input int w, input int ew);
    logic exp_ones;
    logic man_nz;
    exp_ones = 1'b1;
    man_nz   = 1'b0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w - 1 - ew) begin
        man_nz = man_nz | x[i];
      end else if (i < w - 1) begin
        exp_ones = exp_ones & x[i];
      end else begin
        man_nz = man_nz;
      end
    end
    return exp_ones & man_nz;
  endfunction

  // Sign-magnitude to two's complement, so adjacent floats differ by one.
  function automatic logic signed [MAX_W:0] ord_key(input logic [MAX_W-1:0] x, input int w);
    logic [MAX_W:0] mag;
    mag = {1'b0, x & ({MAX_W{1'b1}} >> (MAX_W - w + 1))};
    return x[w-1] ? -$signed(mag) : $signed(mag);
  endfunction

endpackage

// File: rtl/float_ulp_distance.sv
// Combinational ULP distance between two floats, saturated to WIDTH bits,
// with NaN handling: two NaNs agree, a single NaN is a maximal mismatch.
module float_ulp_distance
  import apx_float_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int EXP_W = DEF_EXP_W
) (
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_apx,
  output logic [WIDTH-1:0] o_ulp,
  output logic             o_nan_mismatch
);

  logic [MAX_W-1:0]   w_acc_ext;
  logic [MAX_W-1:0]   w_apx_ext;
  logic               w_acc_nan;
  logic               w_apx_nan;
  logic signed [MAX_W:0] w_diff;
  logic [MAX_W:0]     w_abs;

  assign w_acc_ext = MAX_W'(i_acc);
  assign w_apx_ext = MAX_W'(i_apx);
  assign w_acc_nan = is_nan(w_acc_ext, WIDTH, EXP_W);
  assign w_apx_nan = is_nan(w_apx_ext, WIDTH, EXP_W);
  assign w_diff    = ord_key(w_acc_ext, WIDTH) - ord_key(w_apx_ext, WIDTH);
  assign w_abs     = w_diff[MAX_W] ? $unsigned(-w_diff) : $unsigned(w_diff);

  // Select distance: NaN cases first, then saturated magnitude.
  always_comb begin
    o_ulp          = '0;
    o_nan_mismatch = 1'b0;
    if (w_acc_nan && w_apx_nan) begin
      o_ulp          = '0;
      o_nan_mismatch = 1'b0;
    end else if (w_acc_nan || w_apx_nan) begin
      o_ulp          = '1;
      o_nan_mismatch = 1'b1;
    end else if (|w_abs[MAX_W:WIDTH]) begin
      o_ulp          = '1;
      o_nan_mismatch = 1'b0;
    end else begin
      o_ulp          = w_abs[WIDTH-1:0];
      o_nan_mismatch = 1'b0;
    end
  end

endmodule

// File: rtl/apx_float_error_monitor.sv
// Pairs accurate and approximate float results, reports their ULP distance per
// pair over a stb/ack port and keeps saturating running statistics.
module apx_float_error_monitor
  import apx_float_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int EXP_W   = DEF_EXP_W,
  parameter int CNT_W   = 32,
  parameter int ULP_TOL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] acc_z,
  input  logic             acc_z_stb,
  output logic             acc_z_ack,
  input  logic [WIDTH-1:0] apx_z,
  input  logic             apx_z_stb,
  output logic             apx_z_ack,
  input  logic             clear,
  output logic [WIDTH-1:0] res_ulp,
  output logic             res_mismatch,
  output logic             res_stb,
  input  logic             res_ack,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] mismatch_count,
  output logic [WIDTH-1:0] max_ulp
);

  localparam logic [WIDTH-1:0] TOL = WIDTH'(ULP_TOL);

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_apx;
  logic             r_acc_full;
  logic             r_apx_full;
  logic             r_acc_ack;
  logic             r_apx_ack;
  logic [WIDTH-1:0] r_res_ulp;
  logic             r_res_mismatch;
  logic             r_res_stb;
  logic [CNT_W-1:0] r_sample_count;
  logic [CNT_W-1:0] r_mismatch_count;
  logic [WIDTH-1:0] r_max_ulp;

  logic [WIDTH-1:0] w_ulp;
  logic             w_nan_mismatch;
  logic             w_mismatch;

  float_ulp_distance #(.WIDTH(WIDTH), .EXP_W(EXP_W)) u_dist (
    .i_acc          (r_acc),
    .i_apx          (r_apx),
    .o_ulp          (w_ulp),
    .o_nan_mismatch (w_nan_mismatch)
  );

  assign w_mismatch = w_nan_mismatch | (w_ulp > TOL);

  // Slot capture, compare FSM and result port; acks only rise in COLLECT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= COLLECT;
      r_acc          <= '0;
      r_apx          <= '0;
      r_acc_full     <= 1'b0;
      r_apx_full     <= 1'b0;
      r_acc_ack      <= 1'b0;
      r_apx_ack      <= 1'b0;
      r_res_ulp      <= '0;
      r_res_mismatch <= 1'b0;
      r_res_stb      <= 1'b0;
    end else begin
      case (r_state)
        COLLECT: begin
          if (acc_z_stb && r_acc_ack) begin
            r_acc      <= acc_z;
            r_acc_full <= 1'b1;
            r_acc_ack  <= 1'b0;
          end else begin
            r_acc_ack  <= ~r_acc_full;
          end
          if (apx_z_stb && r_apx_ack) begin
            r_apx      <= apx_z;
            r_apx_full <= 1'b1;
            r_apx_ack  <= 1'b0;
          end else begin
            r_apx_ack  <= ~r_apx_full;
          end
          if (r_acc_full && r_apx_full) begin
            r_state <= COMPARE;
          end else begin
            r_state <= COLLECT;
          end
        end
        COMPARE: begin
          r_res_ulp      <= w_ulp;
          r_res_mismatch <= w_mismatch;
          r_res_stb      <= 1'b1;
          r_state        <= REPORT;
        end
        REPORT: begin
          if (res_ack) begin
            r_res_stb  <= 1'b0;
            r_acc_full <= 1'b0;
            r_apx_full <= 1'b0;
            r_acc_ack  <= 1'b1;
            r_apx_ack  <= 1'b1;
            r_state    <= COLLECT;
          end else begin
            r_state    <= REPORT;
          end
        end
        default: begin
          r_state <= COLLECT;
        end
      endcase
    end
  end

  // Running statistics; clear overrides the COMPARE update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sample_count   <= '0;
      r_mismatch_count <= '0;
      r_max_ulp        <= '0;
    end else if (clear) begin
      r_sample_count   <= '0;
      r_mismatch_count <= '0;
      r_max_ulp        <= '0;
    end else if (r_state == COMPARE) begin
      if (r_sample_count != '1) begin
        r_sample_count <= r_sample_count + CNT_W'(1);
      end else begin
        r_sample_count <= r_sample_count;
      end
      if (w_mismatch && (r_mismatch_count != '1)) begin
        r_mismatch_count <= r_mismatch_count + CNT_W'(1);
      end else begin
        r_mismatch_count <= r_mismatch_count;
      end
      if (w_ulp > r_max_ulp) begin
        r_max_ulp <= w_ulp;
      end else begin
        r_max_ulp <= r_max_ulp;
      end
    end else begin
      r_sample_count   <= r_sample_count;
      r_mismatch_count <= r_mismatch_count;
      r_max_ulp        <= r_max_ulp;
    end
  end

  assign acc_z_ack      = r_acc_ack;
  assign apx_z_ack      = r_apx_ack;
  assign res_ulp        = r_res_ulp;
  assign res_mismatch   = r_res_mismatch;
  assign res_stb        = r_res_stb;
  assign sample_count   = r_sample_count;
  assign mismatch_count = r_mismatch_count;
  assign max_ulp        = r_max_ulp;

endmodule
